// File: rtl/lru_state_array.sv
// Per-set tree pseudo-LRU state storage with victim lookup, touch update and
// a sequenced flush that walks every set.

module lru #(
   parameter int Way      = 8,
   parameter int LruStatW = Way - 1,
   parameter int WaySel   = $clog2(Way)
) (
   input  logic [LruStatW-1:0] state_i,
   input  logic                touch_i,
   input  logic [WaySel-1:0]   way_i,
   output logic [WaySel-1:0]   victim_o,
   output logic [LruStatW-1:0] state_o
);

   logic [LruStatW-1:0] next_st;
   int                  node;

   // Touching a way points every node on its path away from it.
   always_comb begin
      next_st = state_i;
      if (touch_i) begin
         for (int k = 0; k < WaySel; k++) begin
            next_st[(1 << k) - 1 + int'(way_i >> (WaySel - k))] = ~way_i[WaySel-1-k];
         end
      end
   end

   // The victim walk follows the node bits from the root down to a leaf.
   always_comb begin
      node     = 0;
      victim_o = '0;
      for (int k = 0; k < WaySel; k++) begin
         victim_o[WaySel-1-k] = next_st[node];
         node = 2 * node + 1 + int'(next_st[node]);
      end
   end

   assign state_o = next_st;

endmodule

module lru_state_array #(
   parameter int Way      = 8,
   parameter int LruStatW = Way - 1,
   parameter int WaySel   = $clog2(Way),
   parameter int Sets     = 64,
   parameter int SetW     = $clog2(Sets)
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              lookup_valid,
   input  logic [SetW-1:0]   lookup_set,
   output logic              victim_valid,
   output logic [WaySel-1:0] victim_way,
   input  logic              access_valid,
   input  logic [SetW-1:0]   access_set,
   input  logic [WaySel-1:0] access_way,
   input  logic              flush_req,
   output logic              busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } fsm_e;

   localparam logic [SetW:0] LastSet = (SetW + 1)'(Sets - 1);

   fsm_e                fsm_q;
   logic [SetW:0]       cnt_q;
   logic [LruStatW-1:0] state_q [Sets];
   logic                victim_valid_q;
   logic [WaySel-1:0]   victim_way_q;
   logic                busy_q;

   logic                rd_bypass;
   logic [WaySel-1:0]   rd_victim;
   logic [LruStatW-1:0] rd_unused_state;
   logic [WaySel-1:0]   wr_unused_victim;
   logic [LruStatW-1:0] wr_state_d;

   // A same-cycle touch of the looked-up set is folded in before the walk.
   assign rd_bypass = access_valid && (access_set == lookup_set);

   lru #(.Way(Way), .LruStatW(LruStatW), .WaySel(WaySel)) u_rd_lru (
      .state_i  (state_q[lookup_set]),
      .touch_i  (rd_bypass),
      .way_i    (access_way),
      .victim_o (rd_victim),
      .state_o  (rd_unused_state)
   );

   lru #(.Way(Way), .LruStatW(LruStatW), .WaySel(WaySel)) u_wr_lru (
      .state_i  (state_q[access_set]),
      .touch_i  (1'b1),
      .way_i    (access_way),
      .victim_o (wr_unused_victim),
      .state_o  (wr_state_d)
   );

   always_ff @(posedge clk) begin
      if (!reset_) begin
         fsm_q          <= IDLE;
         cnt_q          <= '0;
         victim_valid_q <= 1'b0;
         victim_way_q   <= '0;
         busy_q         <= 1'b0;
         for (int s = 0; s < Sets; s++) begin
            state_q[s] <= '0;
         end
      end else begin
         case (fsm_q)
            IDLE: begin
               if (flush_req) begin
                  fsm_q          <= FLUSH;
                  cnt_q          <= '0;
                  busy_q         <= 1'b1;
                  victim_valid_q <= 1'b0;
               end else begin
                  victim_valid_q <= lookup_valid;
                  if (lookup_valid) begin
                     victim_way_q <= rd_victim;
                  end
                  if (access_valid) begin
                     state_q[access_set] <= wr_state_d;
                  end
               end
            end
            FLUSH: begin
               // Requests arriving while flushing are dropped, not queued.
               state_q[cnt_q[SetW-1:0]] <= '0;
               victim_valid_q           <= 1'b0;
               cnt_q                    <= cnt_q + 1'b1;
               if (cnt_q == LastSet) begin
                  fsm_q  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign victim_valid = victim_valid_q;
   assign victim_way   = victim_way_q;
   assign busy         = busy_q;

endmodule
